axis_nuc_coef_split: RTL and testbench

//  Deinterleaves one packed NUC coefficient stream (DMA, words alternating gain/offset) into the separate

---
 rtl/axis_nuc_coef_split.sv | 246 ++++++++++++++++++++++++
 tb/tb_axis_nuc_coef_split.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_nuc_coef_split.sv
// axis_nuc_coef_split
//   Splits one interleaved NUC coefficient stream (gain word, offset word,
//   gain word, ...) into separate gain and offset AXI4-Stream channels.
//   Each channel has its own 2-entry FIFO. Per-line TLAST is generated from
//   a pair counter. Input TLAST framing is checked and resynchronised.
// Ports
//   axis_aclk / axis_aresetn        clock, async active-low reset
//   s_axis_coef_*                   packed input (even beat gain, odd beat offset)
//   m_axis_gain_*                   gain words, TLAST on last word of line
//   m_axis_ofst_*                   offset words, TLAST on last word of line
//   err_clr                         synchronous clear of sticky flags
//   err_early                       sticky: early TLAST or TLAST on gain word
//   err_missing                     sticky: line end without TLAST

module axis_nuc_coef_split_fifo2 #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output logic [W-1:0] head
);
  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop   = pop && (cnt_q != 2'd0);
    // A push into a full FIFO only lands if the same edge frees a slot.
    do_push  = push && ((cnt_q != 2'd2) || do_pop);
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      if (wr_ptr_q) begin
        slot1_d = push_data;
      end else begin
        slot0_d = push_data;
      end
      wr_ptr_d = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q  <= '0;
      slot1_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign full  = (cnt_q == 2'd2);
  assign valid = (cnt_q != 2'd0);
  assign head  = rd_ptr_q ? slot1_q : slot0_q;
endmodule

module axis_nuc_coef_split #(
  parameter int unsigned LINE_PAIRS = 320
) (
  input  logic        axis_aclk,
  input  logic        axis_aresetn,
  input  logic [31:0] s_axis_coef_tdata,
  input  logic        s_axis_coef_tvalid,
  output logic        s_axis_coef_tready,
  input  logic        s_axis_coef_tlast,
  output logic [31:0] m_axis_gain_tdata,
  output logic        m_axis_gain_tvalid,
  input  logic        m_axis_gain_tready,
  output logic        m_axis_gain_tlast,
  output logic [31:0] m_axis_ofst_tdata,
  output logic        m_axis_ofst_tvalid,
  input  logic        m_axis_ofst_tready,
  output logic        m_axis_ofst_tlast,
  input  logic        err_clr,
  output logic        err_early,
  output logic        err_missing
);
  localparam int unsigned CNT_W = (LINE_PAIRS > 1) ? $clog2(LINE_PAIRS) : 1;
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(LINE_PAIRS - 1);

  typedef enum logic [1:0] {
    ST_GAIN = 2'd0,
    ST_OFST = 2'd1,
    ST_PAD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
  logic             err_early_q, err_early_d;
  logic             err_missing_q, err_missing_d;
  logic             run_q, run_d;

  logic        gain_full, gain_valid, gain_push;
  logic        ofst_full, ofst_valid, ofst_push;
  logic [32:0] gain_head, ofst_head;
  logic [32:0] gain_wdata, ofst_wdata;
  logic        accept, last_pair, word_last;

  assign last_pair = (pair_cnt_q == LAST_PAIR);
  assign word_last = last_pair | s_axis_coef_tlast;
  assign accept    = s_axis_coef_tvalid & s_axis_coef_tready;

  // State register
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q       <= ST_GAIN;
      pair_cnt_q    <= '0;
      err_early_q   <= 1'b0;
      err_missing_q <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pair_cnt_q    <= pair_cnt_d;
      err_early_q   <= err_early_d;
      err_missing_q <= err_missing_d;
      run_q         <= run_d;
    end
  end

  // Next state, pair counter and sticky errors (a new error beats err_clr)
  always_comb begin
    state_d       = state_q;
    pair_cnt_d    = pair_cnt_q;
    err_early_d   = err_clr ? 1'b0 : err_early_q;
    err_missing_d = err_clr ? 1'b0 : err_missing_q;
    run_d         = 1'b1;
    case (state_q)
      ST_GAIN: begin
        if (accept) begin
          if (s_axis_coef_tlast) begin
            err_early_d = 1'b1;
            state_d     = ST_PAD;
          end else begin
            state_d = ST_OFST;
          end
        end
      end
      ST_OFST: begin
        if (accept) begin
          state_d = ST_GAIN;
          if (last_pair) begin
            pair_cnt_d = '0;
            if (!s_axis_coef_tlast) begin
              err_missing_d = 1'b1;
            end
          end else if (s_axis_coef_tlast) begin
            pair_cnt_d  = '0;
            err_early_d = 1'b1;
          end else begin
            pair_cnt_d = pair_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PAD: begin
        if (!ofst_full) begin
          pair_cnt_d = '0;
          state_d    = ST_GAIN;
        end
      end
      default: state_d = ST_GAIN;
    endcase
  end

  // Outputs: input ready and FIFO writes
  always_comb begin
    s_axis_coef_tready = 1'b0;
    gain_push          = 1'b0;
    ofst_push          = 1'b0;
    gain_wdata         = {word_last, s_axis_coef_tdata};
    ofst_wdata         = {word_last, s_axis_coef_tdata};
    case (state_q)
      ST_GAIN: begin
        s_axis_coef_tready = run_q & ~gain_full;
        gain_push          = s_axis_coef_tvalid & run_q & ~gain_full;
      end
      ST_OFST: begin
        s_axis_coef_tready = run_q & ~ofst_full;
        ofst_push          = s_axis_coef_tvalid & run_q & ~ofst_full;
      end
      ST_PAD: begin
        // Zero offset word closes a line that ended on a gain word.
        ofst_push  = ~ofst_full;
        ofst_wdata = {1'b1, 32'h0000_0000};
      end
      default: begin
        s_axis_coef_tready = 1'b0;
      end
    endcase
  end

  axis_nuc_coef_split_fifo2 #(.W(33)) u_gain_fifo (
    .clk       (axis_aclk),
    .rst_n     (axis_aresetn),
    .push      (gain_push),
    .push_data (gain_wdata),
    .pop       (m_axis_gain_tready),
    .full      (gain_full),
    .valid     (gain_valid),
    .head      (gain_head)
  );

  axis_nuc_coef_split_fifo2 #(.W(33)) u_ofst_fifo (
    .clk       (axis_aclk),
    .rst_n     (axis_aresetn),
    .push      (ofst_push),
    .push_data (ofst_wdata),
    .pop       (m_axis_ofst_tready),
    .full      (ofst_full),
    .valid     (ofst_valid),
    .head      (ofst_head)
  );

  assign m_axis_gain_tvalid = gain_valid;
  assign m_axis_gain_tdata  = gain_head[31:0];
  assign m_axis_gain_tlast  = gain_head[32];
  assign m_axis_ofst_tvalid = ofst_valid;
  assign m_axis_ofst_tdata  = ofst_head[31:0];
  assign m_axis_ofst_tlast  = ofst_head[32];
  assign err_early          = err_early_q;
  assign err_missing        = err_missing_q;
endmodule

// File: tb/tb_axis_nuc_coef_split.sv
module tb_axis_nuc_coef_split;
  localparam int LP = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] g_tdata;
  logic        g_tvalid;
  logic        g_tready;
  logic        g_tlast;
  logic [31:0] o_tdata;
  logic        o_tvalid;
  logic        o_tready;
  logic        o_tlast;
  logic        err_clr;
  logic        err_early;
  logic        err_missing;

  axis_nuc_coef_split #(.LINE_PAIRS(LP)) dut (
    .axis_aclk          (clk),
    .axis_aresetn       (rst_n),
    .s_axis_coef_tdata  (s_tdata),
    .s_axis_coef_tvalid (s_tvalid),
    .s_axis_coef_tready (s_tready),
    .s_axis_coef_tlast  (s_tlast),
    .m_axis_gain_tdata  (g_tdata),
    .m_axis_gain_tvalid (g_tvalid),
    .m_axis_gain_tready (g_tready),
    .m_axis_gain_tlast  (g_tlast),
    .m_axis_ofst_tdata  (o_tdata),
    .m_axis_ofst_tvalid (o_tvalid),
    .m_axis_ofst_tready (o_tready),
    .m_axis_ofst_tlast  (o_tlast),
    .err_clr            (err_clr),
    .err_early          (err_early),
    .err_missing        (err_missing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Input beats {tlast, data}, expected and observed output words {tlast, data}
  logic [32:0] in_q[$];
  logic [32:0] exp_g[$];
  logic [32:0] exp_o[$];
  logic [32:0] got_g[$];
  logic [32:0] got_o[$];
  int          acc_cyc[$];
  int          got_g_cyc[$];
  int          got_o_cyc[$];

  // Reference model: position of the next beat within the current line
  int unsigned m_k = 0;
  bit          m_early = 1'b0;
  bit          m_missing = 1'b0;

  int stall_cnt, stab_err, acc_at_hold, o_at_hold;

  task automatic model_accept(input logic [32:0] b);
    int unsigned pair;
    bit tl;
    pair = m_k / 2;
    tl   = b[32];
    if (m_k % 2 == 0) begin
      if (tl) begin
        exp_g.push_back({1'b1, b[31:0]});
        exp_o.push_back({1'b1, 32'h0});
        m_early = 1'b1;
        m_k = 0;
      end else begin
        exp_g.push_back({(pair == LP - 1), b[31:0]});
        m_k = m_k + 1;
      end
    end else begin
      exp_o.push_back({(pair == LP - 1) || tl, b[31:0]});
      if (pair == LP - 1 && !tl) m_missing = 1'b1;
      else if (pair != LP - 1 && tl) m_early = 1'b1;
      m_k = ((pair == LP - 1) || tl) ? 0 : m_k + 1;
    end
  endtask

  task automatic clear_logs();
    in_q.delete(); exp_g.delete(); exp_o.delete(); got_g.delete(); got_o.delete();
    acc_cyc.delete(); got_g_cyc.delete(); got_o_cyc.delete();
  endtask

  // Beat j of a line: gain 1000_000p on even beats, offset 2000_000p on odd
  task automatic add_beats(input int n, input int tl_idx);
    for (int j = 0; j < n; j++) begin
      logic [31:0] d;
      d = ((j % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000) + 32'(j / 2);
      in_q.push_back({(j == tl_idx), d});
    end
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1'b1;
    m_early = 1'b0;
    m_missing = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Streams in_q into the DUT, feeds the model, collects output handshakes.
  task automatic drive(input int g_hold, input bit rnd_v, input bit rnd_r, input int clr_beat);
    int idx, n, idle;
    bit pending, gstall, ostall;
    logic [32:0] gprev, oprev;
    idx = 0; n = 0; idle = 0; pending = 0; gstall = 0; ostall = 0;
    gprev = '0; oprev = '0;
    stall_cnt = 0; stab_err = 0; acc_at_hold = -1; o_at_hold = -1;
    while (n < 2000 && idle < 4) begin
      @(negedge clk);
      err_clr = 1'b0;
      if (!pending && idx < in_q.size()) begin
        if (!rnd_v || $urandom_range(0, 3) != 0) begin
          pending = 1'b1;
          {s_tlast, s_tdata} = in_q[idx];
        end
      end
      s_tvalid = pending;
      g_tready = (n < g_hold) ? 1'b0 : (rnd_r ? ($urandom_range(0, 2) != 0) : 1'b1);
      o_tready = rnd_r ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (s_tvalid && !s_tready) stall_cnt++;
      if (s_tvalid && s_tready) begin
        if (idx == clr_beat) begin
          err_clr = 1'b1;
          m_early = 1'b0;
          m_missing = 1'b0;
        end
        model_accept(in_q[idx]);
        acc_cyc.push_back(cyc);
        idx++;
        pending = 1'b0;
      end
      if (gstall && (!g_tvalid || {g_tlast, g_tdata} !== gprev)) stab_err++;
      if (ostall && (!o_tvalid || {o_tlast, o_tdata} !== oprev)) stab_err++;
      if (g_tvalid && g_tready) begin
        got_g.push_back({g_tlast, g_tdata});
        got_g_cyc.push_back(cyc);
      end
      if (o_tvalid && o_tready) begin
        got_o.push_back({o_tlast, o_tdata});
        got_o_cyc.push_back(cyc);
      end
      gstall = g_tvalid && !g_tready;
      ostall = o_tvalid && !o_tready;
      gprev = {g_tlast, g_tdata};
      oprev = {o_tlast, o_tdata};
      if (n == g_hold - 1) begin
        acc_at_hold = idx;
        o_at_hold = got_o.size();
      end
      if (idx == in_q.size() && got_g.size() >= exp_g.size() && got_o.size() >= exp_o.size())
        idle++;
      n++;
    end
    checks++;
    if (idle < 4) begin
      errors++;
      $display("FAIL drive_timeout: accepted %0d of %0d beats, gain %0d/%0d ofst %0d/%0d",
               idx, in_q.size(), got_g.size(), exp_g.size(), got_o.size(), exp_o.size());
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    err_clr = 1'b0;
    g_tready = 1'b1;
    o_tready = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({g_tvalid, o_tvalid, g_tlast, o_tlast, s_tready, err_early, err_missing} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got gv=%b ov=%b gl=%b ol=%b rdy=%b ee=%b em=%b, required all 0",
               g_tvalid, o_tvalid, g_tlast, o_tlast, s_tready, err_early, err_missing);
    end
    checks++;
    if (g_tdata !== 32'h0 || o_tdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got gain %h ofst %h, required 0", g_tdata, o_tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    clear_logs();
    add_beats(2 * LP, 2 * LP - 1);
    drive(0, 1'b0, 1'b0, -1);
    checks++;
    if (got_g.size() != exp_g.size() || got_o.size() != exp_o.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d/%0d, required %0d/%0d", got_g.size(), got_o.size(), exp_g.size(), exp_o.size());
    end
    for (int i = 0; i < exp_g.size() && i < got_g.size(); i++) begin
      checks++;
      if (got_g[i] !== exp_g[i]) begin errors++; $display("FAIL basic_gain[%0d]: got %h required %h", i, got_g[i], exp_g[i]); end
    end
    for (int i = 0; i < exp_o.size() && i < got_o.size(); i++) begin
      checks++;
      if (got_o[i] !== exp_o[i]) begin errors++; $display("FAIL basic_ofst[%0d]: got %h required %h", i, got_o[i], exp_o[i]); end
    end
    checks++;
    if (got_g.size() == LP && got_g[LP-1] !== {1'b1, 32'h1000_0003}) begin
      errors++; $display("FAIL basic_gain_last: got %h required 1_10000003", got_g[LP-1]);
    end
    if (got_g_cyc.size() == LP && got_o_cyc.size() == LP && acc_cyc.size() == 2 * LP) begin
      for (int i = 0; i < LP; i++) begin
        checks++;
        if (got_g_cyc[i] != acc_cyc[2*i] + 1 || got_o_cyc[i] != acc_cyc[2*i+1] + 1) begin
          errors++;
          $display("FAIL basic_latency[%0d]: out cycles %0d/%0d, required %0d/%0d", i,
                   got_g_cyc[i], got_o_cyc[i], acc_cyc[2*i] + 1, acc_cyc[2*i+1] + 1);
        end
      end
      checks++;
      if (acc_cyc[2*LP-1] - acc_cyc[0] != 2 * LP - 1) begin
        errors++; $display("FAIL basic_throughput: span %0d cycles required %0d", acc_cyc[2*LP-1] - acc_cyc[0], 2 * LP - 1);
      end
    end
    checks++;
    if (stall_cnt != 0 || err_early !== 1'b0 || err_missing !== 1'b0) begin
      errors++; $display("FAIL basic_flags: stalls %0d ee=%b em=%b, required 0 0 0", stall_cnt, err_early, err_missing);
    end
  endtask

  task automatic test_gain_stall();
    clear_logs();
    add_beats(2 * LP, 2 * LP - 1);
    drive(20, 1'b0, 1'b0, -1);
    checks++;
    if (acc_at_hold != 4 || o_at_hold != 2 || stall_cnt == 0) begin
      errors++;
      $display("FAIL stall_hold: accepted %0d ofst out %0d stalls %0d, required 4 2 >0", acc_at_hold, o_at_hold, stall_cnt);
    end
    checks++;
    if (got_g.size() != exp_g.size() || got_o.size() != exp_o.size()) begin
      errors++; $display("FAIL stall_count: got %0d/%0d required %0d/%0d", got_g.size(), got_o.size(), exp_g.size(), exp_o.size());
    end
    for (int i = 0; i < exp_g.size() && i < got_g.size(); i++) begin
      checks++;
      if (got_g[i] !== exp_g[i]) begin errors++; $display("FAIL stall_gain[%0d]: got %h required %h", i, got_g[i], exp_g[i]); end
    end
    for (int i = 0; i < exp_o.size() && i < got_o.size(); i++) begin
      checks++;
      if (got_o[i] !== exp_o[i]) begin errors++; $display("FAIL stall_ofst[%0d]: got %h required %h", i, got_o[i], exp_o[i]); end
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL stall_stable: %0d changes while stalled, required 0", stab_err); end
  endtask

  task automatic test_early_ofst();
    clear_errs();
    clear_logs();
    add_beats(4, 3);
    add_beats(2 * LP, 2 * LP - 1);
    drive(0, 1'b0, 1'b0, -1);
    checks++;
    if (got_g.size() != exp_g.size() || got_o.size() != exp_o.size()) begin
      errors++; $display("FAIL early_o_count: got %0d/%0d required %0d/%0d", got_g.size(), got_o.size(), exp_g.size(), exp_o.size());
    end
    for (int i = 0; i < exp_g.size() && i < got_g.size(); i++) begin
      checks++;
      if (got_g[i] !== exp_g[i]) begin errors++; $display("FAIL early_o_gain[%0d]: got %h required %h", i, got_g[i], exp_g[i]); end
    end
    for (int i = 0; i < exp_o.size() && i < got_o.size(); i++) begin
      checks++;
      if (got_o[i] !== exp_o[i]) begin errors++; $display("FAIL early_o_ofst[%0d]: got %h required %h", i, got_o[i], exp_o[i]); end
    end
    checks++;
    if (err_early !== m_early || err_missing !== m_missing || m_early != 1'b1) begin
      errors++; $display("FAIL early_o_flags: got ee=%b em=%b required ee=%b em=%b", err_early, err_missing, m_early, m_missing);
    end
  endtask

  task automatic test_early_gain_pad();
    clear_errs();
    clear_logs();
    add_beats(5, 4);
    add_beats(2 * LP, 2 * LP - 1);
    drive(0, 1'b0, 1'b0, -1);
    checks++;
    if (stall_cnt != 1) begin errors++; $display("FAIL pad_stall: got %0d not-ready cycles, required 1", stall_cnt); end
    checks++;
    if (got_o.size() < 3 || got_o[2] !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL pad_word: ofst count %0d, word2 %h, required 1_00000000", got_o.size(), (got_o.size() > 2) ? got_o[2] : 33'h0);
    end
    checks++;
    if (got_g.size() != exp_g.size() || got_o.size() != exp_o.size()) begin
      errors++; $display("FAIL pad_count: got %0d/%0d required %0d/%0d", got_g.size(), got_o.size(), exp_g.size(), exp_o.size());
    end
    for (int i = 0; i < exp_g.size() && i < got_g.size(); i++) begin
      checks++;
      if (got_g[i] !== exp_g[i]) begin errors++; $display("FAIL pad_gain[%0d]: got %h required %h", i, got_g[i], exp_g[i]); end
    end
    for (int i = 0; i < exp_o.size() && i < got_o.size(); i++) begin
      checks++;
      if (got_o[i] !== exp_o[i]) begin errors++; $display("FAIL pad_ofst[%0d]: got %h required %h", i, got_o[i], exp_o[i]); end
    end
    checks++;
    if (err_early !== 1'b1 || err_missing !== 1'b0) begin
      errors++; $display("FAIL pad_flags: got ee=%b em=%b required 1 0", err_early, err_missing);
    end
  endtask

  task automatic test_missing_and_clr();
    clear_errs();
    clear_logs();
    add_beats(2 * LP, -1);
    drive(0, 1'b0, 1'b0, -1);
    for (int i = 0; i < exp_o.size() && i < got_o.size(); i++) begin
      checks++;
      if (got_o[i] !== exp_o[i]) begin errors++; $display("FAIL miss_ofst[%0d]: got %h required %h", i, got_o[i], exp_o[i]); end
    end
    checks++;
    if (got_g.size() != LP || got_o.size() != LP || got_g[LP-1][32] !== 1'b1) begin
      errors++; $display("FAIL miss_gain_last: got %0d/%0d words, required %0d with tlast on last gain", got_g.size(), got_o.size(), LP);
    end
    checks++;
    if (err_missing !== 1'b1 || err_early !== 1'b0) begin
      errors++; $display("FAIL miss_flag: got em=%b ee=%b required 1 0", err_missing, err_early);
    end
    clear_errs();
    #1;
    checks++;
    if (err_missing !== 1'b0) begin errors++; $display("FAIL miss_clr: got em=%b required 0", err_missing); end
    clear_logs();
    add_beats(2 * LP, -1);
    drive(0, 1'b0, 1'b0, 2 * LP - 1);
    checks++;
    if (err_missing !== 1'b1 || m_missing != 1'b1) begin
      errors++; $display("FAIL miss_set_wins: got em=%b required 1", err_missing);
    end
  endtask

  task automatic test_reset_midline();
    int w;
    clear_logs();
    add_beats(3, -1);
    g_tready = 1'b0;
    o_tready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      {s_tlast, s_tdata} = in_q[b];
      #1;
      w = 0;
      while (!s_tready && w < 20) begin @(negedge clk); #1; w++; end
      checks++;
      if (w >= 20) begin errors++; $display("FAIL rstmid_accept[%0d]: tready stayed 0, required 1", b); end
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    checks++;
    if (g_tvalid !== 1'b1 || o_tvalid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pending: got gv=%b ov=%b required 1 1", g_tvalid, o_tvalid);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({g_tvalid, o_tvalid, s_tready, err_early, err_missing} !== 5'b0) begin
      errors++; $display("FAIL rstmid_clear: got gv=%b ov=%b rdy=%b ee=%b em=%b required all 0",
                         g_tvalid, o_tvalid, s_tready, err_early, err_missing);
    end
    g_tready = 1'b1;
    o_tready = 1'b1;
    m_k = 0; m_early = 1'b0; m_missing = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_logs();
    add_beats(2 * LP, 2 * LP - 1);
    drive(0, 1'b0, 1'b0, -1);
    checks++;
    if (got_g.size() != exp_g.size() || got_o.size() != exp_o.size()) begin
      errors++; $display("FAIL rstmid_count: got %0d/%0d required %0d/%0d", got_g.size(), got_o.size(), exp_g.size(), exp_o.size());
    end
    for (int i = 0; i < exp_g.size() && i < got_g.size(); i++) begin
      checks++;
      if (got_g[i] !== exp_g[i]) begin errors++; $display("FAIL rstmid_gain[%0d]: got %h required %h", i, got_g[i], exp_g[i]); end
    end
    for (int i = 0; i < exp_o.size() && i < got_o.size(); i++) begin
      checks++;
      if (got_o[i] !== exp_o[i]) begin errors++; $display("FAIL rstmid_ofst[%0d]: got %h required %h", i, got_o[i], exp_o[i]); end
    end
    checks++;
    if (err_early !== 1'b0 || err_missing !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: got ee=%b em=%b required 0 0", err_early, err_missing);
    end
  endtask

  task automatic test_random();
    clear_errs();
    clear_logs();
    for (int l = 0; l < 10; l++) begin
      int kind, p, nb, tl;
      kind = $urandom_range(0, 9);
      p = $urandom_range(0, LP - 2);
      nb = 2 * LP; tl = 2 * LP - 1;
      if (kind == 0) begin nb = 2 * p + 1; tl = 2 * p; end
      else if (kind == 1) begin nb = 2 * p + 2; tl = 2 * p + 1; end
      else if (kind == 2) begin tl = -1; end
      for (int j = 0; j < nb; j++) in_q.push_back({(j == tl), 32'($urandom)});
    end
    drive(0, 1'b1, 1'b1, -1);
    checks++;
    if (got_g.size() != exp_g.size() || got_o.size() != exp_o.size()) begin
      errors++; $display("FAIL rand_count: got %0d/%0d required %0d/%0d", got_g.size(), got_o.size(), exp_g.size(), exp_o.size());
    end
    for (int i = 0; i < exp_g.size() && i < got_g.size(); i++) begin
      checks++;
      if (got_g[i] !== exp_g[i]) begin errors++; $display("FAIL rand_gain[%0d]: got %h required %h", i, got_g[i], exp_g[i]); end
    end
    for (int i = 0; i < exp_o.size() && i < got_o.size(); i++) begin
      checks++;
      if (got_o[i] !== exp_o[i]) begin errors++; $display("FAIL rand_ofst[%0d]: got %h required %h", i, got_o[i], exp_o[i]); end
    end
    checks++;
    if (stab_err != 0) begin errors++; $display("FAIL rand_stable: %0d changes while stalled, required 0", stab_err); end
    checks++;
    if (err_early !== m_early || err_missing !== m_missing) begin
      errors++; $display("FAIL rand_flags: got ee=%b em=%b required ee=%b em=%b", err_early, err_missing, m_early, m_missing);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_tdata = '0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    g_tready = 1'b1;
    o_tready = 1'b1;
    err_clr = 1'b0;
    test_reset();
    test_basic();
    test_gain_stall();
    test_early_ofst();
    test_early_gain_pad();
    test_missing_and_clr();
    test_reset_midline();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
